// File: rtl/model_loader.sv
// Model loader: turns a host word stream into CSRAM row writes and token-controller
// weight writes, and sequences rst_model/rst_network. Define LOADER_CHECKSUM_EN for END checksum.
module model_loader #(
  parameter int NUM_CORES        = 4,
  parameter int NUM_NEURONS      = 256,
  parameter int NUM_AXONS        = 256,
  parameter int NUM_WEIGHTS      = 4,
  parameter int CSRAM_READ_WIDTH = 367,
  parameter int IN_WIDTH         = 32,
  localparam int CORE_W = $clog2(NUM_CORES),
  localparam int ADDR_W = $clog2(NUM_NEURONS),
  localparam int AXON_W = $clog2(NUM_AXONS),
  localparam int WGT_W  = $clog2(NUM_WEIGHTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IN_WIDTH-1:0]         in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        rst_model,
  output logic                        rst_network,
  output logic [CSRAM_READ_WIDTH-1:0] csram_data,
  output logic [ADDR_W-1:0]           csram_addr,
  output logic [CORE_W-1:0]           csram_core_idx,
  output logic                        csram_valid,
  output logic [WGT_W-1:0]            tc_data,
  output logic [AXON_W-1:0]           tc_addr,
  output logic [CORE_W-1:0]           tc_core_idx,
  output logic                        tc_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_CLEAR       = 3'd1;
  localparam logic [2:0] S_HEADER      = 3'd2;
  localparam logic [2:0] S_CSRAM_BEAT  = 3'd3;
  localparam logic [2:0] S_CSRAM_WRITE = 3'd4;
  localparam logic [2:0] S_TC_BEAT     = 3'd5;
  localparam logic [2:0] S_DONE        = 3'd6;
  localparam logic [2:0] S_ERROR       = 3'd7;

  localparam int BEATS  = (CSRAM_READ_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int HOLD_W = CSRAM_READ_WIDTH - IN_WIDTH;
  localparam logic [31:0] NUM_CORES_L   = NUM_CORES;
  localparam logic [31:0] NUM_NEURONS_L = NUM_NEURONS;

  logic [2:0]                  state, nxt;
  logic [HOLD_W-1:0]           shift_q;
  logic [CSRAM_READ_WIDTH-1:0] shift_nxt;
  logic [BEAT_W-1:0]           beat_cnt;
  logic [15:0]                 row_cnt, blk_count;
  logic [CORE_W-1:0]           blk_core;
  logic                        xfer, last_beat, hdr_bad, csum_ok;
  logic [1:0]                  hdr_type;
  logic [13:0]                 hdr_core;
  logic [15:0]                 hdr_count;

  assign xfer      = in_valid & in_ready;
  assign hdr_type  = in_data[31:30];
  assign hdr_core  = in_data[29:16];
  assign hdr_count = in_data[15:0];
  assign hdr_bad   = ({18'd0, hdr_core} >= NUM_CORES_L) || (hdr_count == 16'd0) ||
                     ((hdr_type == 2'd0) && ({16'd0, hdr_count} > NUM_NEURONS_L));
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  // Only the low row-width bits survive, so MSB-first pad bits fall off the top.
  assign shift_nxt = {shift_q, in_data};

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum;
  assign csum_ok = (csum == hdr_count);

  always_ff @(posedge clk) begin
    if (!rst)
      csum <= 16'd0;
    else if (state == S_CLEAR)
      csum <= 16'd0;
    else if (xfer && (state == S_CSRAM_BEAT || state == S_TC_BEAT))
      csum <= csum + in_data[15:0];
  end
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:        if (start) nxt = S_CLEAR;
      S_CLEAR:       nxt = S_HEADER;
      S_HEADER: begin
        if (xfer) begin
          case (hdr_type)
            2'd0:    nxt = hdr_bad ? S_ERROR : S_CSRAM_BEAT;
            2'd1:    nxt = hdr_bad ? S_ERROR : S_TC_BEAT;
            2'd2:    nxt = csum_ok ? S_DONE : S_ERROR;
            default: nxt = S_ERROR;
          endcase
        end
      end
      S_CSRAM_BEAT:  if (xfer && last_beat) nxt = S_CSRAM_WRITE;
      S_CSRAM_WRITE: nxt = (row_cnt + 16'd1 == blk_count) ? S_HEADER : S_CSRAM_BEAT;
      S_TC_BEAT:     if (xfer && (row_cnt + 16'd1 == blk_count)) nxt = S_HEADER;
      S_DONE:        if (start) nxt = S_CLEAR;
      S_ERROR:       if (start) nxt = S_CLEAR;
      default:       nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      in_ready       <= 1'b0;
      rst_model      <= 1'b0;
      rst_network    <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      csram_valid    <= 1'b0;
      tc_valid       <= 1'b0;
      csram_data     <= '0;
      csram_addr     <= '0;
      csram_core_idx <= '0;
      tc_data        <= '0;
      tc_addr        <= '0;
      tc_core_idx    <= '0;
      shift_q        <= '0;
      beat_cnt       <= '0;
      row_cnt        <= '0;
      blk_count      <= '0;
      blk_core       <= '0;
    end else begin
      state       <= nxt;
      in_ready    <= (nxt == S_HEADER) || (nxt == S_CSRAM_BEAT) || (nxt == S_TC_BEAT);
      rst_model   <= !((nxt == S_IDLE) || (nxt == S_CLEAR));
      rst_network <= (nxt != S_DONE);
      busy        <= (nxt == S_CLEAR) || (nxt == S_HEADER) || (nxt == S_CSRAM_BEAT) ||
                     (nxt == S_CSRAM_WRITE) || (nxt == S_TC_BEAT);
      done        <= (nxt == S_DONE);
      error       <= (nxt == S_ERROR);
      csram_valid <= (nxt == S_CSRAM_WRITE);
      tc_valid    <= (state == S_TC_BEAT) && xfer;

      if (state == S_HEADER && xfer) begin
        blk_core  <= hdr_core[CORE_W-1:0];
        blk_count <= hdr_count;
        row_cnt   <= 16'd0;
        beat_cnt  <= '0;
      end

      if (state == S_CSRAM_BEAT && xfer) begin
        shift_q  <= shift_nxt[HOLD_W-1:0];
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (last_beat) begin
          csram_data     <= shift_nxt;
          csram_addr     <= row_cnt[ADDR_W-1:0];
          csram_core_idx <= blk_core;
        end
      end

      if (state == S_CSRAM_WRITE)
        row_cnt <= row_cnt + 16'd1;

      if (state == S_TC_BEAT && xfer) begin
        tc_addr     <= in_data[16 +: AXON_W];
        tc_data     <= in_data[WGT_W-1:0];
        tc_core_idx <= blk_core;
        row_cnt     <= row_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/model_loader.md
Name: model_loader

Overview:
- Sequences model programming for the core mesh. It consumes a host word stream and turns it into per-core CSRAM row writes (csram_*) and token-controller weight writes (tc_*), both on the shared broadcast buses.
- Drives rst_model and rst_network around the load, so cores are cleared, programmed, activated and released in the correct order.
- Sits between the host/DMA interface and the core array, one instance per mesh.

Parameters:
- NUM_CORES, 4, cores on broadcast buses; core_idx width = $clog2(NUM_CORES)
- NUM_NEURONS, 256, CSRAM rows per core
- NUM_AXONS, 256, axons per core
- NUM_WEIGHTS, 4, weight types
- CSRAM_READ_WIDTH, 367, CSRAM row width
- IN_WIDTH, 32, host word width (>=32)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when IDLE or DONE
- in_data  in  IN_WIDTH  host word
- in_valid  in  1  host word valid
- in_ready  out  1  loader accepts word (transfer = in_valid & in_ready)
- rst_model  out  1  to cores; low clears core_active, high permits model writes
- rst_network  out  1  to cores; active-high network reset
- csram_data  out  CSRAM_READ_WIDTH  row to write
- csram_addr  out  $clog2(NUM_NEURONS)  row address
- csram_core_idx  out  $clog2(NUM_CORES)  target core
- csram_valid  out  1  one-cycle write strobe
- tc_data  out  $clog2(NUM_WEIGHTS)  axon weight type
- tc_addr  out  $clog2(NUM_AXONS)  axon address
- tc_core_idx  out  $clog2(NUM_CORES)  target core
- tc_valid  out  1  one-cycle write strobe
- busy  out  1  load in progress
- done  out  1  high in DONE
- error  out  1  sticky until rst or start

Behaviour:
- Reset (rst=0):
  - State IDLE.
  - rst_model=0, rst_network=1, in_ready=0, csram_valid=tc_valid=0.
  - All data/addr/idx outputs 0; busy=done=error=0.
- Host word formats:
  - Header: type=[31:30], core=[29:16] (low bits used), count=[15:0].
  - type 0 = CSRAM block of count rows, addresses 0..count-1.
  - type 1 = TC block of count beats.
  - type 2 = END.
  - type 3 = illegal.
- States:
  - IDLE: wait for start.
  - CLEAR (1 cycle): rst_model=0, rst_network=1, error cleared. Then rst_model=1 until next rst/start.
  - HEADER: in_ready=1; decode on transfer.
    - Type 0/1 go to CSRAM_BEAT/TC_BEAT.
    - END goes to DONE.
    - type 3, core>=NUM_CORES, count==0, or type 0 with count>NUM_NEURONS all go to ERROR.
  - CSRAM_BEAT: in_ready=1.
    - Accept BEATS=ceil(CSRAM_READ_WIDTH/IN_WIDTH) words (12 at defaults), MSB-first, shifted into a register.
    - Row = low CSRAM_READ_WIDTH bits of the concatenation; leading pad bits are discarded.
    - After the last beat, go to CSRAM_WRITE.
  - CSRAM_WRITE (1 cycle): in_ready=0, csram_valid=1 with row/addr/core.
    - Row counter increments.
    - Next state is CSRAM_BEAT, or HEADER after count rows.
  - TC_BEAT: in_ready=1.
    - Each transfer drives tc_valid=1 for exactly the next cycle, with tc_addr=word[16 +: $clog2(NUM_AXONS)] and tc_data=word[$clog2(NUM_WEIGHTS)-1:0].
    - After count beats, go to HEADER. A tc_addr out-of-range is impossible by width truncation.
  - DONE: rst_network=0, rst_model=1, done=1; cores run.
  - ERROR: error=1, rst_network=1, in_ready=0; wait for start or rst.
- Signal rules:
  - busy=1 in CLEAR..TC_BEAT.
  - rst_network=1 in every state except DONE.
  - Outputs are registered. csram_valid and tc_valid are never high in the same cycle.
- Latency:
  - Last CSRAM beat transfer to csram_valid is 1 cycle.
  - TC beat transfer to tc_valid is 1 cycle.
  - END transfer to done is 1 cycle.
- Boundaries:
  - in_valid low mid-row: counters hold; no timeout.
  - start while busy: ignored.
  - start in DONE or ERROR: restarts at CLEAR, which clears all cores again.
  - rst mid-load: immediate return to reset values; partial row discarded, no strobe.
  - Row counter wraps only via the count<=NUM_NEURONS check.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- With it:
  - A 16-bit running sum (mod 2^16) of word[15:0] over all payload words (not headers) is kept.
  - Checksum is cleared in CLEAR.
  - The END header's count field carries the expected sum; a mismatch goes to ERROR instead of DONE.
- Without it: the END count field is ignored; no checksum logic is present.

Test Plan:
- Reset then start, header {0, core 1, count 2}, 24 payload words -> two csram_valid pulses, addr 0 then 1, csram_core_idx=1, data equal to the packed rows, in_ready=0 during each write cycle.
- Header {1, core 0, count 3}, words addr 5/data 2, addr 255/data 3, addr 0/data 1 -> three tc_valid pulses, each 1 cycle after its transfer, with matching addr/data.
- END after loads -> done=1 and rst_network=0 next cycle; rst_model low exactly one cycle after start.
- Header core=NUM_CORES (4), or type 3, or type 0 with count=257 -> error=1, rst_network=1, no strobes; a following start clears error.
- in_valid toggling every other cycle mid-row, then rst=0 at beat 6 -> no csram_valid, all outputs at reset values next cycle.
- LOADER_CHECKSUM_EN: correct END sum -> done; sum off by 1 -> error=1, done=0.
